// File: rtl/nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// nn_layer_sequencer
//
// Control sequencer for a fully-connected neural-network layer pipeline.
// For every layer it streams one MAC beat per (neuron, input) pair to a MAC
// engine, optionally hands the accumulated sum to a CORDIC activation unit,
// and writes one result per neuron into the ping-pong result bank.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               level; a run begins on its 0->1 edge while idle
//   no_layers           number of layers in the run
//   nl_flat             neurons per layer, layer L at [L*NW +: NW]
//   af_flat             activation per layer (00 sigm, 01 tanh, 10 relu, 11 lin)
//   n_in                input dimension (fan-in of layer 0)
//   mac_ready           MAC engine accepts the presented beat
//   act_ack             activation unit has finished
//   busy / done / err   run in progress / end-of-run pulse / sticky cfg error
//   mac_valid/first/last  MAC beat handshake and neuron framing
//   w_addr, x_addr      weight address and source-operand index of the beat
//   src_bank            ping-pong bank read during the current layer
//   act_req, act_mode   activation request and function for the current layer
//   wr_en, wr_addr      result write strobe and neuron index
//   layer_idx           current layer
// All outputs are registers.
// -----------------------------------------------------------------------------
module nn_layer_sequencer #(
    parameter int MAX_LAYERS = 5,
    parameter int NW         = 6,
    parameter int IW         = 10,
    parameter int AW         = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [$clog2(MAX_LAYERS+1)-1:0]   no_layers,
    input  logic [MAX_LAYERS*NW-1:0]          nl_flat,
    input  logic [MAX_LAYERS*2-1:0]           af_flat,
    input  logic [IW-1:0]                     n_in,
    input  logic                              mac_ready,
    input  logic                              act_ack,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic                              mac_valid,
    output logic                              mac_first,
    output logic                              mac_last,
    output logic [AW-1:0]                     w_addr,
    output logic [IW-1:0]                     x_addr,
    output logic                              src_bank,
    output logic                              act_req,
    output logic [1:0]                        act_mode,
    output logic                              wr_en,
    output logic [NW-1:0]                     wr_addr,
    output logic [$clog2(MAX_LAYERS)-1:0]     layer_idx
);

    localparam int LCW = $clog2(MAX_LAYERS + 1);
    localparam int LIW = $clog2(MAX_LAYERS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MAC   = 3'd2,
        ACT   = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state_q;
    logic               start_q;

    // Configuration latched at the accepted start edge
    logic [LCW-1:0]     no_layers_q;
    logic [NW-1:0]      nl_q [MAX_LAYERS];
    logic [1:0]         af_q [MAX_LAYERS];
    logic [IW-1:0]      n_in_q;

    // Position counters
    logic [LIW-1:0]     layer_q;
    logic [NW-1:0]      neuron_q;
    logic [IW-1:0]      x_q;
    logic [AW-1:0]      w_q;
    logic               bank_q;

    // Output registers
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               mac_valid_q;
    logic               mac_first_q;
    logic               mac_last_q;
    logic               act_req_q;
    logic [1:0]         act_mode_q;
    logic               wr_en_q;
    logic [NW-1:0]      wr_addr_q;

    // Derived control terms
    logic               start_edge_s;
    logic               cfg_bad_s;
    logic [NW-1:0]      cur_nl_s;
    logic [IW-1:0]      fanin_s;
    logic [LIW-1:0]     next_layer_s;
    logic               last_beat_s;
    logic               next_is_last_s;
    logic               last_neuron_s;
    logic               last_layer_s;
    logic               linear_s;

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mac_valid = mac_valid_q;
    assign mac_first = mac_first_q;
    assign mac_last  = mac_last_q;
    assign w_addr    = w_q;
    assign x_addr    = x_q;
    assign src_bank  = bank_q;
    assign act_req   = act_req_q;
    assign act_mode  = act_mode_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign layer_idx = layer_q;

    // Start edge and configuration sanity check on the latched configuration
    always_comb begin
        start_edge_s = start & ~start_q;
        cfg_bad_s    = (no_layers_q == {LCW{1'b0}})
                     | (no_layers_q > LCW'(MAX_LAYERS))
                     | (n_in_q == {IW{1'b0}});
        for (int l = 0; l < MAX_LAYERS; l++) begin
            // Only layers that are actually part of the run must be non-empty
            cfg_bad_s = cfg_bad_s
                      | ((LCW'(l) < no_layers_q) && (nl_q[l] == {NW{1'b0}}));
        end
    end

    // Per-layer geometry: fan-in is n_in for layer 0, else previous layer width
    always_comb begin
        cur_nl_s     = nl_q[layer_q];
        next_layer_s = layer_q + LIW'(1);
        if (layer_q == {LIW{1'b0}}) begin
            fanin_s = n_in_q;
        end else begin
            fanin_s = IW'(nl_q[layer_q - LIW'(1)]);
        end
        last_beat_s    = (x_q == fanin_s - IW'(1));
        next_is_last_s = ((x_q + IW'(1)) == (fanin_s - IW'(1)));
        last_neuron_s  = (neuron_q == cur_nl_s - NW'(1));
        last_layer_s   = ((LCW'(layer_q) + LCW'(1)) == no_layers_q);
        linear_s       = (act_mode_q == 2'b11);
    end

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            // Track the live start level so a start held through reset
            // release is not seen as a fresh edge.
            start_q     <= start;
            no_layers_q <= {LCW{1'b0}};
            n_in_q      <= {IW{1'b0}};
            for (int l = 0; l < MAX_LAYERS; l++) begin
                nl_q[l] <= {NW{1'b0}};
                af_q[l] <= 2'b00;
            end
            layer_q     <= {LIW{1'b0}};
            neuron_q    <= {NW{1'b0}};
            x_q         <= {IW{1'b0}};
            w_q         <= {AW{1'b0}};
            bank_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            act_req_q   <= 1'b0;
            act_mode_q  <= 2'b00;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= {NW{1'b0}};
        end else begin
            start_q <= start;
            case (state_q)
                IDLE: begin
                    if (start_edge_s) begin
                        no_layers_q <= no_layers;
                        n_in_q      <= n_in;
                        for (int l = 0; l < MAX_LAYERS; l++) begin
                            nl_q[l] <= nl_flat[l*NW +: NW];
                            af_q[l] <= af_flat[l*2 +: 2];
                        end
                        layer_q  <= {LIW{1'b0}};
                        neuron_q <= {NW{1'b0}};
                        x_q      <= {IW{1'b0}};
                        w_q      <= {AW{1'b0}};
                        bank_q   <= 1'b0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= CHECK;
                    end
                end

                CHECK: begin
                    if (cfg_bad_s) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        // Layer 0, neuron 0: fan-in is the input dimension
                        mac_valid_q <= 1'b1;
                        mac_first_q <= 1'b1;
                        mac_last_q  <= (n_in_q == IW'(1));
                        act_mode_q  <= af_q[0];
                        state_q     <= MAC;
                    end
                end

                MAC: begin
                    // Beat only moves on when the MAC engine takes it;
                    // otherwise x/w addresses hold.
                    if (mac_ready) begin
                        w_q <= w_q + AW'(1);
                        if (last_beat_s) begin
                            mac_valid_q <= 1'b0;
                            mac_first_q <= 1'b0;
                            mac_last_q  <= 1'b0;
                            x_q         <= {IW{1'b0}};
                            if (linear_s) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= neuron_q;
                                state_q   <= WRITE;
                            end else begin
                                act_req_q <= 1'b1;
                                state_q   <= ACT;
                            end
                        end else begin
                            x_q         <= x_q + IW'(1);
                            mac_first_q <= 1'b0;
                            mac_last_q  <= next_is_last_s;
                        end
                    end
                end

                ACT: begin
                    if (act_ack) begin
                        act_req_q <= 1'b0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= neuron_q;
                        state_q   <= WRITE;
                    end
                end

                WRITE: begin
                    wr_en_q <= 1'b0;
                    if (!last_neuron_s) begin
                        neuron_q    <= neuron_q + NW'(1);
                        mac_valid_q <= 1'b1;
                        mac_first_q <= 1'b1;
                        mac_last_q  <= (fanin_s == IW'(1));
                        state_q     <= MAC;
                    end else if (!last_layer_s) begin
                        // Next layer reads what this layer just wrote, so
                        // its fan-in is this layer's neuron count.
                        layer_q     <= next_layer_s;
                        neuron_q    <= {NW{1'b0}};
                        bank_q      <= ~bank_q;
                        act_mode_q  <= af_q[next_layer_s];
                        mac_valid_q <= 1'b1;
                        mac_first_q <= 1'b1;
                        mac_last_q  <= (cur_nl_s == NW'(1));
                        state_q     <= MAC;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    mac_valid_q <= 1'b0;
                    mac_first_q <= 1'b0;
                    mac_last_q  <= 1'b0;
                    act_req_q   <= 1'b0;
                    wr_en_q     <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
module tb_nn_layer_sequencer;

    localparam int ML  = 5;
    localparam int NW  = 6;
    localparam int IW  = 10;
    localparam int AW  = 16;
    localparam int LCW = $clog2(ML + 1);
    localparam int LIW = $clog2(ML);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LCW-1:0]    no_layers;
    logic [ML*NW-1:0]  nl_flat;
    logic [ML*2-1:0]   af_flat;
    logic [IW-1:0]     n_in;
    logic              mac_ready;
    logic              act_ack;
    logic              busy, done, err, mac_valid, mac_first, mac_last;
    logic [AW-1:0]     w_addr;
    logic [IW-1:0]     x_addr;
    logic              src_bank, act_req, wr_en;
    logic [1:0]        act_mode;
    logic [NW-1:0]     wr_addr;
    logic [LIW-1:0]    layer_idx;

    nn_layer_sequencer #(.MAX_LAYERS(ML), .NW(NW), .IW(IW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .no_layers(no_layers),
        .nl_flat(nl_flat), .af_flat(af_flat), .n_in(n_in),
        .mac_ready(mac_ready), .act_ack(act_ack),
        .busy(busy), .done(done), .err(err),
        .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
        .w_addr(w_addr), .x_addr(x_addr), .src_bank(src_bank),
        .act_req(act_req), .act_mode(act_mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .layer_idx(layer_idx)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Run configuration as the bench sees it
    int cfg_nlay;
    int cfg_nin;
    int cfg_nl [ML];
    int cfg_af [ML];

    typedef struct { int w; int x; int first; int last; int layer; int bank; } beat_t;
    typedef struct { int n; int layer; int bank; int act; int af; } wr_t;
    beat_t exp_beats [$];
    wr_t   exp_wrs   [$];

    function automatic bit cfg_bad();
        bit b = (cfg_nlay == 0) || (cfg_nlay > ML) || (cfg_nin == 0);
        for (int l = 0; l < ML; l++)
            if (l < cfg_nlay && cfg_nl[l] == 0) b = 1'b1;
        return b;
    endfunction

    // Reference model: enumerate every beat and write the run must produce
    task automatic build_model();
        int w;
        int fan;
        beat_t b;
        wr_t   r;
        exp_beats.delete();
        exp_wrs.delete();
        w = 0;
        if (cfg_bad()) return;
        for (int l = 0; l < cfg_nlay; l++) begin
            fan = (l == 0) ? cfg_nin : cfg_nl[l-1];
            for (int n = 0; n < cfg_nl[l]; n++) begin
                for (int x = 0; x < fan; x++) begin
                    b.w = w % (1 << AW); b.x = x; b.first = (x == 0); b.last = (x == fan - 1);
                    b.layer = l; b.bank = l % 2;
                    exp_beats.push_back(b);
                    w++;
                end
                r.n = n; r.layer = l; r.bank = l % 2; r.act = (cfg_af[l] != 3); r.af = cfg_af[l];
                exp_wrs.push_back(r);
            end
        end
    endtask

    task automatic apply_cfg();
        no_layers = LCW'(cfg_nlay);
        n_in      = IW'(cfg_nin);
        for (int l = 0; l < ML; l++) begin
            nl_flat[l*NW +: NW] = NW'(cfg_nl[l]);
            af_flat[l*2 +: 2]   = 2'(cfg_af[l]);
        end
    endtask

    task automatic set_net(input int nlay, input int nin, input int n0, input int n1,
                           input int n2, input int af);
        cfg_nlay = nlay; cfg_nin = nin;
        cfg_nl[0] = n0; cfg_nl[1] = n1; cfg_nl[2] = n2; cfg_nl[3] = 1; cfg_nl[4] = 1;
        for (int l = 0; l < ML; l++) cfg_af[l] = af;
    endtask

    function automatic logic all_out_zero();
        return ({busy, done, err, mac_valid, mac_first, mac_last, src_bank, act_req,
                 wr_en, act_mode} == 12'd0) && (w_addr == '0) && (x_addr == '0)
               && (wr_addr == '0) && (layer_idx == '0);
    endfunction

    // One run: start edge, per-cycle monitor against the model, end checks.
    // rdy_mode: 0 always ready, 1 random, 2 pattern 1,0,0,1 in layer 0.
    task automatic run_case(input string name, input int rdy_mode, input int ack_dly,
                            input int hold_cycles, input bit glitch, input bit abort_l1);
        bit    bad, finished, prev_stall, prev_last_xfer, prev_act;
        int    dones, ack_cnt, cyc;
        logic [AW-1:0] prev_w;
        logic [IW-1:0] prev_x;
        beat_t b;
        wr_t   r;
        build_model();
        bad = cfg_bad();
        @(negedge clk);
        apply_cfg();
        start = 1'b1;
        @(negedge clk);
        // Scramble configuration inputs: the run must use the latched copy
        no_layers = LCW'($urandom); nl_flat = ML*NW'($urandom);
        af_flat = 10'($urandom); n_in = IW'($urandom);
        check_eq({name, ":busy_T1"}, busy, 1);
        check_eq({name, ":valid_T1"}, mac_valid, 0);
        check_eq({name, ":err_clr_T1"}, err, 0);
        @(negedge clk);
        if (bad) begin
            check_eq({name, ":bad_done_T2"}, done, 1);
            check_eq({name, ":bad_err_T2"}, err, 1);
            check_eq({name, ":bad_valid"}, mac_valid, 0);
            @(negedge clk);
            check_eq({name, ":bad_done_once"}, done, 0);
            check_eq({name, ":bad_idle"}, busy, 0);
            start = 1'b0;
            repeat (3) @(negedge clk);
            check_eq({name, ":err_sticky"}, err, 1);
            return;
        end
        check_eq({name, ":valid_T2"}, mac_valid, 1);
        finished = 0; prev_stall = 0; prev_last_xfer = 0; prev_act = 0;
        dones = 0; ack_cnt = 0; prev_w = '0; prev_x = '0;
        for (cyc = 0; cyc < 4000 && !finished; cyc++) begin
            if (glitch && cyc == 3) start = 1'b0;
            else if (glitch && cyc == 5) start = 1'b1;
            else if (!glitch && cyc == hold_cycles) start = 1'b0;

            if (abort_l1 && act_req && layer_idx == LIW'(1)) begin
                rst = 1'b1; act_ack = 1'b0; start = 1'b0;
                @(negedge clk);
                check_eq({name, ":rst_outputs_zero"}, all_out_zero(), 1);
                rst = 1'b0;
                @(negedge clk);
                check_eq({name, ":rst_stays_idle"}, busy, 0);
                exp_beats.delete(); exp_wrs.delete();
                return;
            end

            case (rdy_mode)
                0:       mac_ready = 1'b1;
                1:       mac_ready = 1'($urandom_range(0, 1));
                default: mac_ready = (layer_idx == '0) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            endcase

            if (prev_stall) begin
                check_eq({name, ":stall_hold_w"}, w_addr, prev_w);
                check_eq({name, ":stall_hold_x"}, x_addr, prev_x);
                check_eq({name, ":stall_valid"}, mac_valid, 1);
            end

            if (mac_valid && mac_ready) begin
                if (exp_beats.size() == 0) begin
                    check_eq({name, ":extra_beat"}, 1, 0);
                end else begin
                    b = exp_beats.pop_front();
                    check_eq({name, ":w_addr"}, w_addr, b.w);
                    check_eq({name, ":x_addr"}, x_addr, b.x);
                    check_eq({name, ":first"}, mac_first, b.first);
                    check_eq({name, ":last"}, mac_last, b.last);
                    check_eq({name, ":beat_layer"}, layer_idx, b.layer);
                    check_eq({name, ":beat_bank"}, src_bank, b.bank);
                end
            end

            if (act_req) begin
                if (!prev_act) begin
                    if (exp_wrs.size() == 0) begin
                        check_eq({name, ":extra_act"}, 1, 0);
                    end else begin
                        check_eq({name, ":act_expected"}, 1, exp_wrs[0].act);
                        check_eq({name, ":act_mode"}, act_mode, exp_wrs[0].af);
                    end
                end
                act_ack = (ack_cnt >= ack_dly);
                ack_cnt++;
            end else begin
                ack_cnt = 0;
                act_ack = ($urandom_range(0, 3) == 0); // stray acks must be ignored
            end

            if (wr_en) begin
                if (exp_wrs.size() == 0) begin
                    check_eq({name, ":extra_write"}, 1, 0);
                end else begin
                    r = exp_wrs.pop_front();
                    check_eq({name, ":wr_addr"}, wr_addr, r.n);
                    check_eq({name, ":wr_layer"}, layer_idx, r.layer);
                    check_eq({name, ":wr_bank"}, src_bank, r.bank);
                    if (!r.act) check_eq({name, ":wr_follows_last"}, prev_last_xfer, 1);
                end
            end

            prev_stall     = mac_valid && !mac_ready;
            prev_last_xfer = mac_valid && mac_ready && mac_last;
            prev_act       = act_req;
            prev_w         = w_addr;
            prev_x         = x_addr;

            if (done) begin
                dones++;
                finished = 1;
                check_eq({name, ":done_busy"}, busy, 1);
                check_eq({name, ":done_err"}, err, 0);
            end else begin
                @(negedge clk);
            end
        end
        if (!finished) check_eq({name, ":timeout"}, 0, 1);
        act_ack = 1'b0;
        @(negedge clk);
        check_eq({name, ":done_pulse"}, done, 0);
        check_eq({name, ":idle_busy"}, busy, 0);
        check_eq({name, ":beats_left"}, exp_beats.size(), 0);
        check_eq({name, ":writes_left"}, exp_wrs.size(), 0);
        check_eq({name, ":done_count"}, dones, 1);
        repeat (5) @(negedge clk);
        check_eq({name, ":no_retrigger"}, busy || mac_valid, 0);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; mac_ready = 1'b1; act_ack = 1'b0;
        set_net(3, 2, 2, 3, 2, 0);
        apply_cfg();
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", all_out_zero(), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("start_through_reset", busy, 0);
        start = 1'b0;
        @(negedge clk);

        set_net(3, 2, 2, 3, 2, 0);  run_case("basic", 0, 3, 1, 0, 0);
        set_net(3, 2, 2, 3, 2, 3);  run_case("linear", 0, 0, 1, 0, 0);
        set_net(3, 2, 2, 3, 2, 0);  run_case("stall", 2, 3, 1, 0, 0);
        set_net(0, 2, 2, 3, 2, 0);  run_case("no_layers0", 0, 0, 1, 0, 0);
        set_net(3, 2, 2, 3, 0, 0);  run_case("nl2_zero", 0, 0, 1, 0, 0);
        set_net(3, 2, 2, 3, 2, 0);  run_case("err_clear", 0, 1, 1, 0, 0);
        set_net(6, 2, 2, 3, 2, 0);  run_case("too_many", 0, 0, 1, 0, 0);
        set_net(3, 0, 2, 3, 2, 0);  run_case("n_in0", 0, 0, 1, 0, 0);
        set_net(3, 2, 2, 3, 2, 0);  run_case("abort", 0, 3, 1, 0, 1);
        set_net(3, 2, 2, 3, 2, 0);  run_case("after_abort", 0, 3, 1, 0, 0);
        set_net(3, 2, 2, 3, 2, 0);  run_case("held_start", 0, 3, 100, 0, 0);
        set_net(3, 2, 2, 3, 2, 0);  run_case("restart_busy", 1, 2, 1, 1, 0);
        set_net(2, 1, 1, 1, 1, 1);  run_case("fanin1", 1, 0, 1, 0, 0);

        for (int it = 0; it < 25; it++) begin
            cfg_nlay = $urandom_range(1, ML);
            cfg_nin  = $urandom_range(1, 5);
            for (int l = 0; l < ML; l++) begin
                cfg_nl[l] = (l < cfg_nlay) ? $urandom_range(1, 4) : $urandom_range(0, 4);
                cfg_af[l] = $urandom_range(0, 3);
            end
            run_case($sformatf("rand%0d", it), $urandom_range(0, 2), $urandom_range(0, 4),
                     $urandom_range(1, 20), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nn_layer_sequencer.md
NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

Interface
REQ-001 SHALL have parameter MAX_LAYERS, default 5: maximum supported layer count.
REQ-002 SHALL have parameter NW, default 6: neuron-count and index width.
REQ-003 SHALL have parameter IW, default 10: input-dimension width.
REQ-004 SHALL have parameter AW, default 16: weight-address width.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports, as name  direction  width  meaning:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  level; run begins on its 0->1 edge.
- no_layers  in  $clog2(MAX_LAYERS+1)  layer count.
- nl_flat  in  MAX_LAYERS*NW  neurons per layer; layer L at bits [L*NW +: NW].
- af_flat  in  MAX_LAYERS*2  activation per layer: 00 sigmoid, 01 tanh, 10 relu, 11 linear.
- n_in  in  IW  input dimension.
- mac_ready  in  1  MAC engine accepts a beat.
- act_ack  in  1  CORDIC activation complete.
- busy  out  1  run in progress.
- done  out  1  one-cycle end-of-run pulse.
- err  out  1  sticky config error.
- mac_valid  out  1  MAC beat valid.
- mac_first  out  1  first beat of a neuron (clear accumulator).
- mac_last  out  1  last beat of a neuron.
- w_addr  out  AW  weight address.
- x_addr  out  IW  source-operand index.
- src_bank  out  1  ping-pong bank read this layer.
- act_req  out  1  activation request.
- act_mode  out  2  activation for the current layer.
- wr_en  out  1  result write strobe.
- wr_addr  out  NW  result neuron index.
- layer_idx  out  $clog2(MAX_LAYERS)  current layer.

Function
REQ-007 SHALL use states IDLE, CHECK, MAC, ACT, WRITE, DONE.
REQ-008 SHALL latch all configuration inputs when a start edge occurs in IDLE; later changes are ignored until the next run.
REQ-009 SHALL ignore start edges outside IDLE; a held-high start SHALL NOT retrigger a run.
REQ-010 CHECK SHALL set err and go to DONE if any holds: no_layers==0; no_layers>MAX_LAYERS; n_in==0; nl==0 for any layer below no_layers. Otherwise CHECK SHALL go to MAC at layer 0, neuron 0, x 0.
REQ-011 SHALL use fan-in n_in for layer 0 and nl[L-1] for layer L>0.
REQ-012 MAC state: mac_valid=1; a beat transfers only when mac_ready=1; x_addr and w_addr SHALL hold while mac_ready=0.
REQ-013 SHALL assert mac_first on the beat with x_addr==0 and mac_last on the beat with x_addr==fanin-1; both SHALL be set together when fanin==1.
REQ-014 w_addr SHALL start at 0 each run and increment by 1 per transferred beat across all neurons and layers; it SHALL wrap modulo 2^AW.
REQ-015 After the last beat transfers, SHALL go to ACT, or directly to WRITE when act_mode==11.
REQ-016 ACT: act_req=1 and act_mode=af[layer] held until act_ack=1 is sampled; SHALL then go to WRITE. act_ack outside ACT SHALL be ignored.
REQ-017 WRITE: wr_en=1 for exactly one cycle with wr_addr=neuron index; results go to bank ~src_bank.
REQ-018 After WRITE: if neuron<nl[layer]-1, neuron+1 and go to MAC; else if layer<no_layers-1, layer+1, neuron 0, toggle src_bank and go to MAC; else go to DONE.
REQ-019 DONE SHALL pulse done for one cycle and then go to IDLE; the final results are in bank ~src_bank.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 err SHALL stay set until the next accepted start, which clears it.
REQ-022 Timing: with a start edge sampled at cycle T, CHECK is at T+1; the first mac_valid is at T+2.

Reset
REQ-023 rst SHALL force IDLE at any time, including mid-run, with no done pulse.
REQ-024 On rst, all outputs SHALL be 0, all counters 0, src_bank 0 and the start edge detector cleared; a start held high through rst release SHALL NOT trigger a run.

Verification
REQ-025 n_in=2, nl=2,3,2, no_layers=3, af=00, mac_ready=1, act_ack returned 3 cycles after act_req -> 16 beats, w_addr 0..15, 7 wr_en pulses (wr_addr 0,1 / 0,1,2 / 0,1), src_bank 0,1,0, one done, err=0.
REQ-026 Same network with af=11 on all layers -> act_req never asserted; each WRITE follows mac_last by one cycle.
REQ-027 mac_ready toggled 1,0,0,1 during layer 0 -> no beat lost or duplicated, w_addr held during stalls, total still 16.
REQ-028 no_layers=0, or nl2=0 with no_layers=3 -> no mac_valid, err=1, done pulse at T+2; the next valid start clears err.
REQ-029 rst asserted in layer 1 ACT -> all outputs 0 next cycle; a fresh start reruns from w_addr 0.
REQ-030 start held high 1000 ns -> exactly one run; a second start edge while busy -> ignored.
